// File: rtl/cyclonev_soc_pio_pkg.sv
// ----------------------------------------------------------------------------
// cyclonev_soc_pio_pkg
// Shared definitions for the HPS-side PIO blocks on the lightweight bridge.
//   - Avalon word addresses of the PIO registers
//   - Edge-capture selection encodings (EDGE_TYPE parameter values)
//   - Width helper for the per-bit debounce counter
// ----------------------------------------------------------------------------
package cyclonev_soc_pio_pkg;

    // Register word addresses (2-bit Avalon word address)
    localparam logic [1:0] PIO_DATA    = 2'd0;
    localparam logic [1:0] PIO_RSVD    = 2'd1;
    localparam logic [1:0] PIO_MASK    = 2'd2;
    localparam logic [1:0] PIO_EDGECAP = 2'd3;

    // Edge-capture selection
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Counter must hold 0..cycles; never narrower than one bit so the
    // declaration stays legal for tiny debounce settings.
    function automatic int deb_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage : cyclonev_soc_pio_pkg

// File: rtl/cyclonev_soc_pio_debounce.sv
// ----------------------------------------------------------------------------
// cyclonev_soc_pio_debounce
// Single-bit synchroniser followed by a stability-counter debouncer.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   din       in   raw asynchronous input bit
//   deb       out  debounced level (resets to 1, the button idle level)
//   deb_rise  out  high for the one cycle before the edge on which deb rises
//   deb_fall  out  high for the one cycle before the edge on which deb falls
// The rise/fall pulses are decoded from flop state so a consumer can register
// the event on exactly the same edge that deb itself changes.
// ----------------------------------------------------------------------------
module cyclonev_soc_pio_debounce
    import cyclonev_soc_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic deb,
    output logic deb_rise,
    output logic deb_fall
);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_bit;
    logic                   update;

    assign sync_bit = sync_chain[SYNC_STAGES-1];

    // Metastability chain; idles high so reset release shows no edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], din};
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // Bypass: accept any synchronised change on the next edge
            always_comb begin
                update = (sync_bit != deb);
            end
        end else begin : g_count
            localparam int CNT_W = deb_cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt;
            logic [CNT_W-1:0] cnt_next;

            // Count consecutive disagreeing cycles; any agreement restarts it
            always_comb begin
                cnt_next = cnt;
                update   = 1'b0;
                if (sync_bit == deb) begin
                    cnt_next = {CNT_W{1'b0}};
                end else if (cnt == CNT_LAST) begin
                    cnt_next = {CNT_W{1'b0}};
                    update   = 1'b1;
                end else begin
                    cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            // Stability counter register
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt <= {CNT_W{1'b0}};
                end else begin
                    cnt <= cnt_next;
                end
            end
        end
    endgenerate

    // Debounced level register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb <= 1'b1;
        end else if (update) begin
            deb <= sync_bit;
        end else begin
            deb <= deb;
        end
    end

    // update implies sync_bit != deb, so the new level gives the direction
    assign deb_rise = update & sync_bit;
    assign deb_fall = update & ~sync_bit;

endmodule : cyclonev_soc_pio_debounce

// File: rtl/cyclonev_soc_key_pio.sv
// ----------------------------------------------------------------------------
// cyclonev_soc_key_pio
// Avalon-MM input PIO for push-buttons/switches with per-bit debounce, edge
// capture and a maskable level interrupt. Zero wait states, read latency 0.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   [1:0] word address (0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGECAP)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   [31:0] write data
//   readdata    out  [31:0] read data, zero-extended above DATA_WIDTH
//   in_port     in   [DATA_WIDTH-1:0] raw asynchronous inputs
//   irq         out  level interrupt, |(EDGECAP & IRQ_MASK)
// ----------------------------------------------------------------------------
module cyclonev_soc_key_pio
    import cyclonev_soc_pio_pkg::*;
#(
    parameter int DATA_WIDTH      = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int EDGE_TYPE       = 1,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] deb;
    logic [DATA_WIDTH-1:0] deb_rise;
    logic [DATA_WIDTH-1:0] deb_fall;
    logic [DATA_WIDTH-1:0] edge_set;
    logic [DATA_WIDTH-1:0] irq_mask;
    logic [DATA_WIDTH-1:0] edgecap;
    logic [DATA_WIDTH-1:0] edgecap_next;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wr_en;

    assign wr_en = chipselect & ~write_n;
    assign wdata = writedata[DATA_WIDTH-1:0];

    generate
        if (DATA_WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata_hi;
            assign unused_wdata_hi = &{1'b0, writedata[31:DATA_WIDTH]};
        end
    endgenerate

    // One synchroniser + debouncer per input bit
    generate
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
            cyclonev_soc_pio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_debounce (
                .clk      (clk),
                .reset_n  (reset_n),
                .din      (in_port[i]),
                .deb      (deb[i]),
                .deb_rise (deb_rise[i]),
                .deb_fall (deb_fall[i])
            );
        end
    endgenerate

    // Select which debounced transitions are captured
    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISING:  edge_set = deb_rise;
            EDGE_FALLING: edge_set = deb_fall;
            EDGE_ANY:     edge_set = deb_rise | deb_fall;
            default:      edge_set = deb_fall;
        endcase
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= {DATA_WIDTH{1'b0}};
        end else if (wr_en && (address == PIO_MASK)) begin
            irq_mask <= wdata;
        end else begin
            irq_mask <= irq_mask;
        end
    end

    // W1C clear first, then OR in new edges so a colliding edge is kept
    always_comb begin
        edgecap_next = edgecap;
        if (wr_en && (address == PIO_EDGECAP)) begin
            edgecap_next = (edgecap & ~wdata) | edge_set;
        end else begin
            edgecap_next = edgecap | edge_set;
        end
    end

    // Edge-capture register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= {DATA_WIDTH{1'b0}};
        end else begin
            edgecap <= edgecap_next;
        end
    end

    // Combinational read mux; zero above DATA_WIDTH and for reserved words
    always_comb begin
        readdata = 32'h0000_0000;
        case (address)
            PIO_DATA:    readdata[DATA_WIDTH-1:0] = deb;
            PIO_RSVD:    readdata = 32'h0000_0000;
            PIO_MASK:    readdata[DATA_WIDTH-1:0] = irq_mask;
            PIO_EDGECAP: readdata[DATA_WIDTH-1:0] = edgecap;
            default:     readdata = 32'h0000_0000;
        endcase
    end

    // Built only from flops, so no combinational glitching on irq
    assign irq = |(edgecap & irq_mask);

endmodule : cyclonev_soc_key_pio

// File: tb/tb_cyclonev_soc_key_pio.sv
module tb_cyclonev_soc_key_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int checks;
    int errors;

    cyclonev_soc_key_pio #(
        .DATA_WIDTH      (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (1),
        .SYNC_STAGES     (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset_n    = 1'b0;
        in_port    = 4'hF;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        bus_read(2'd0, d); checks++;
        if (d !== 32'h0000_000F) begin errors++; $display("FAIL reset_data got %h want %h", d, 32'hF); end
        bus_read(2'd2, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_mask got %h want %h", d, 32'h0); end
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_edgecap got %h want %h", d, 32'h0); end
        bus_read(2'd1, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_rsvd got %h want %h", d, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    endtask

    task automatic test_registers();
        logic [31:0] d;
        bus_write(2'd0, 32'h0000_0000);
        bus_read(2'd0, d); checks++;
        if (d !== 32'h0000_000F) begin errors++; $display("FAIL data_ro got %h want %h", d, 32'hF); end
        bus_write(2'd2, 32'hFFFF_FFF5);
        bus_read(2'd2, d); checks++;
        if (d !== 32'h0000_0005) begin errors++; $display("FAIL mask_rw got %h want %h", d, 32'h5); end
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rsvd_rd got %h want %h", d, 32'h0); end
        bus_write(2'd2, 32'h0000_0000);
        bus_read(2'd2, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mask_clr got %h want %h", d, 32'h0); end
    endtask

    task automatic test_debounce_latency();
        logic [31:0] d;
        in_port[0] = 1'b0;
        tick(5);
        bus_read(2'd0, d); checks++;
        if (d !== 32'h0000_000F) begin errors++; $display("FAIL lat_early got %h want %h", d, 32'hF); end
        tick(1);
        bus_read(2'd0, d); checks++;
        if (d !== 32'h0000_000E) begin errors++; $display("FAIL lat_data got %h want %h", d, 32'hE); end
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL lat_edgecap got %h want %h", d, 32'h1); end
        in_port[0] = 1'b1;
        tick(8);
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL rise_ignored got %h want %h", d, 32'h1); end
        bus_write(2'd3, 32'h0000_0001);
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL w1c_bit0 got %h want %h", d, 32'h0); end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        in_port[1] = 1'b0;
        tick(3);
        in_port[1] = 1'b1;
        tick(2);
        bus_read(2'd0, d); checks++;
        if (d !== 32'h0000_000F) begin errors++; $display("FAIL glitch_mid got %h want %h", d, 32'hF); end
        tick(8);
        bus_read(2'd0, d); checks++;
        if (d !== 32'h0000_000F) begin errors++; $display("FAIL glitch_data got %h want %h", d, 32'hF); end
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL glitch_edgecap got %h want %h", d, 32'h0); end
    endtask

    task automatic test_irq_mask();
        logic [31:0] d;
        in_port[2] = 1'b0;
        tick(8);
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0000_0004) begin errors++; $display("FAIL irq_edgecap got %h want %h", d, 32'h4); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b want 0", irq); end
        bus_write(2'd2, 32'h0000_0004);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmasked got %b want 1", irq); end
        bus_write(2'd3, 32'h0000_0004);
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL irq_w1c got %h want %h", d, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_cleared got %b want 0", irq); end
        in_port[2] = 1'b1;
        tick(8);
    endtask

    task automatic test_collision();
        logic [31:0] d;
        in_port[3] = 1'b0;
        tick(5);
        bus_write(2'd3, 32'h0000_0008);
        bus_read(2'd0, d); checks++;
        if (d !== 32'h0000_0007) begin errors++; $display("FAIL coll_data got %h want %h", d, 32'h7); end
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0000_0008) begin errors++; $display("FAIL coll_edgecap got %h want %h", d, 32'h8); end
        bus_write(2'd3, 32'h0000_0008);
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL coll_w1c got %h want %h", d, 32'h0); end
        in_port[3] = 1'b1;
        tick(8);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        in_port[1] = 1'b0;
        tick(8);
        in_port[1] = 1'b1;
        tick(8);
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL rm_pre_edgecap got %h want %h", d, 32'h2); end
        in_port[0] = 1'b0;
        tick(3);
        reset_n = 1'b0;
        #1;
        bus_read(2'd0, d); checks++;
        if (d !== 32'h0000_000F) begin errors++; $display("FAIL rm_data got %h want %h", d, 32'hF); end
        bus_read(2'd2, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rm_mask got %h want %h", d, 32'h0); end
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL rm_edgecap got %h want %h", d, 32'h0); end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rm_irq got %b want 0", irq); end
        tick(2);
        reset_n = 1'b1;
        tick(5);
        bus_read(2'd0, d); checks++;
        if (d !== 32'h0000_000F) begin errors++; $display("FAIL rm_lat_early got %h want %h", d, 32'hF); end
        tick(1);
        bus_read(2'd0, d); checks++;
        if (d !== 32'h0000_000E) begin errors++; $display("FAIL rm_lat_data got %h want %h", d, 32'hE); end
        bus_read(2'd3, d); checks++;
        if (d !== 32'h0000_0001) begin errors++; $display("FAIL rm_lat_edgecap got %h want %h", d, 32'h1); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_registers();
        test_debounce_latency();
        test_glitch();
        test_irq_mask();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cyclonev_soc_key_pio
